bnn_mem0_sequencer: RTL and testbench



---
 rtl/bnn_mem0_sequencer_if.sv | 32 +++
 rtl/bnn_mem0_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_bnn_mem0_sequencer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_mem0_sequencer_if.sv
// MEM0 port B and core row/result handshake signals of the BNN memory sequencer.
// master = sequencer side, slave = MEM0 plus compute-core side.
interface bnn_mem0_sequencer_if #(
  parameter int DATA_W = 28,
  parameter int ADDR_W = 6,
  parameter int CLS_W  = 4
);
  logic [ADDR_W-1:0] oMEM0ADDR;
  logic              oMEM0Rd_EN;
  logic              oMEM0Wr_EN;
  logic [DATA_W-1:0] oMEM0WrDATA;
  logic [DATA_W-1:0] iMEM0RdDATA;
  logic [DATA_W-1:0] oROW_DATA;
  logic              oROW_VALID;
  logic              oROW_LAST;
  logic              iROW_READY;
  logic              iRES_VALID;
  logic [CLS_W-1:0]  iRES_CLASS;
  logic              oRES_READY;

  modport master (
    output oMEM0ADDR, oMEM0Rd_EN, oMEM0Wr_EN, oMEM0WrDATA,
    output oROW_DATA, oROW_VALID, oROW_LAST, oRES_READY,
    input  iMEM0RdDATA, iROW_READY, iRES_VALID, iRES_CLASS
  );

  modport slave (
    input  oMEM0ADDR, oMEM0Rd_EN, oMEM0Wr_EN, oMEM0WrDATA,
    input  oROW_DATA, oROW_VALID, oROW_LAST, oRES_READY,
    output iMEM0RdDATA, iROW_READY, iRES_VALID, iRES_CLASS
  );
endinterface

// File: rtl/bnn_mem0_sequencer.sv
// Fetches N_ROWS image rows from MEM0, streams them to the BNN core, writes the class back.
// First row valid RD_LAT+2 cycles after iSTART; a stalled row holds until READY, no refetch.
module bnn_mem0_sequencer #(
  parameter int N_ROWS    = 28,
  parameter int DATA_W    = 28,
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0,
  parameter int RES_ADDR  = 28,
  parameter int CLS_W     = 4,
  parameter int RD_LAT    = 2
) (
  input  logic                 iCLK,
  input  logic                 iRSTn,
  input  logic                 iCLR,
  input  logic                 iSTART,
  bnn_mem0_sequencer_if.master bus,
  output logic                 oBUSY,
  output logic                 oDONE
);
  localparam int CNT_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int LAT_W = $clog2(RD_LAT + 1);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] RES_A  = ADDR_W'(RES_ADDR);
  localparam logic [CNT_W-1:0]  LAST_ROW = CNT_W'(N_ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_PRESENT, S_WAIT_RES, S_WR_RES, S_DONE
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   row_cnt, row_cnt_n;
  logic [LAT_W-1:0]   lat_cnt, lat_cnt_n;
  logic [ADDR_W-1:0]  addr_q, addr_n;
  logic [DATA_W-1:0]  row_data_q, row_data_n;
  logic [DATA_W-1:0]  wr_data_q, wr_data_n;
  logic               rd_en_q, rd_en_n;
  logic               wr_en_q, wr_en_n;
  logic               valid_q, valid_n;
  logic               last_q, last_n;
  logic               res_rdy_q, res_rdy_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;

  always_comb begin
    state_n    = state;
    row_cnt_n  = row_cnt;
    lat_cnt_n  = lat_cnt;
    addr_n     = addr_q;
    row_data_n = row_data_q;
    wr_data_n  = wr_data_q;
    rd_en_n    = 1'b0;
    wr_en_n    = 1'b0;
    valid_n    = 1'b0;
    last_n     = 1'b0;
    res_rdy_n  = 1'b0;
    done_n     = 1'b0;

    case (state)
      S_IDLE: begin
        if (iSTART) begin
          state_n   = S_RD_REQ;
          row_cnt_n = '0;
          rd_en_n   = 1'b1;
          addr_n    = BASE_A;
        end
      end
      S_RD_REQ: begin
        state_n   = S_RD_WAIT;
        lat_cnt_n = LAT_W'(RD_LAT - 1);
      end
      S_RD_WAIT: begin
        // Counter reaches zero in the cycle RD_LAT after the Rd_EN cycle.
        if (lat_cnt == '0) begin
          state_n    = S_PRESENT;
          row_data_n = bus.iMEM0RdDATA;
          valid_n    = 1'b1;
          last_n     = (row_cnt == LAST_ROW);
        end else begin
          lat_cnt_n = lat_cnt - LAT_W'(1);
        end
      end
      S_PRESENT: begin
        valid_n = 1'b1;
        last_n  = last_q;
        if (bus.iROW_READY) begin
          valid_n = 1'b0;
          last_n  = 1'b0;
          if (last_q) begin
            state_n   = S_WAIT_RES;
            res_rdy_n = 1'b1;
          end else begin
            state_n   = S_RD_REQ;
            row_cnt_n = row_cnt + CNT_W'(1);
            rd_en_n   = 1'b1;
            addr_n    = BASE_A + ADDR_W'(row_cnt + CNT_W'(1));
          end
        end
      end
      S_WAIT_RES: begin
        res_rdy_n = 1'b1;
        if (bus.iRES_VALID) begin
          state_n   = S_WR_RES;
          res_rdy_n = 1'b0;
          wr_en_n   = 1'b1;
          addr_n    = RES_A;
          wr_data_n = DATA_W'(bus.iRES_CLASS);
        end
      end
      S_WR_RES: begin
        state_n = S_DONE;
        done_n  = 1'b1;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Synchronous clear aborts any run, including a pending result write.
    if (iCLR) begin
      state_n    = S_IDLE;
      row_cnt_n  = '0;
      lat_cnt_n  = '0;
      addr_n     = '0;
      row_data_n = '0;
      wr_data_n  = '0;
      rd_en_n    = 1'b0;
      wr_en_n    = 1'b0;
      valid_n    = 1'b0;
      last_n     = 1'b0;
      res_rdy_n  = 1'b0;
      done_n     = 1'b0;
    end
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state      <= S_IDLE;
      row_cnt    <= '0;
      lat_cnt    <= '0;
      addr_q     <= '0;
      row_data_q <= '0;
      wr_data_q  <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      res_rdy_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_n;
      row_cnt    <= row_cnt_n;
      lat_cnt    <= lat_cnt_n;
      addr_q     <= addr_n;
      row_data_q <= row_data_n;
      wr_data_q  <= wr_data_n;
      rd_en_q    <= rd_en_n;
      wr_en_q    <= wr_en_n;
      valid_q    <= valid_n;
      last_q     <= last_n;
      res_rdy_q  <= res_rdy_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
    end
  end

  assign bus.oMEM0ADDR   = addr_q;
  assign bus.oMEM0Rd_EN  = rd_en_q;
  assign bus.oMEM0Wr_EN  = wr_en_q;
  assign bus.oMEM0WrDATA = wr_data_q;
  assign bus.oROW_DATA   = row_data_q;
  assign bus.oROW_VALID  = valid_q;
  assign bus.oROW_LAST   = last_q;
  assign bus.oRES_READY  = res_rdy_q;
  assign oBUSY           = busy_q;
  assign oDONE           = done_q;
endmodule

// File: tb/tb_bnn_mem0_sequencer.sv
// Directed bench: three sequencers with RD_LAT = 1, 2, 3, each on its own MEM0 model
// holding 28'h100+addr; instance 1 (RD_LAT=2) carries the functional scenarios.
module tb_bnn_mem0_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] start, clr, ready, res_valid;
  logic [3:0] res_class;
  logic [2:0] busy, done, vld, lst, rden, wren, rrdy;
  logic [2:0][27:0] dat, wdat;
  logic [2:0][5:0]  adr;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bnn_mem0_sequencer_if #(.DATA_W(28), .ADDR_W(6), .CLS_W(4)) bus ();
    logic [27:0] pipe [3];
    logic [2:0]  vpipe;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int clash  = 0;

    // Read data is only driven in the exact cycle RD_LAT after Rd_EN; junk otherwise.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) vpipe <= '0;
      else begin
        vpipe   <= {vpipe[1:0], bus.oMEM0Rd_EN};
        pipe[0] <= 28'h100 + {22'd0, bus.oMEM0ADDR};
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
      end
    end
    assign bus.iMEM0RdDATA = vpipe[g] ? pipe[g] : 28'hBADBADB;

    always @(posedge clk) begin
      if (bus.oMEM0Rd_EN) rd_cnt <= rd_cnt + 1;
      if (bus.oMEM0Wr_EN) wr_cnt <= wr_cnt + 1;
      if (bus.oMEM0Rd_EN && bus.oMEM0Wr_EN) clash <= clash + 1;
    end

    assign bus.iROW_READY = ready[g];
    assign bus.iRES_VALID = res_valid[g];
    assign bus.iRES_CLASS = res_class;
    assign vld[g]  = bus.oROW_VALID;
    assign lst[g]  = bus.oROW_LAST;
    assign rden[g] = bus.oMEM0Rd_EN;
    assign wren[g] = bus.oMEM0Wr_EN;
    assign rrdy[g] = bus.oRES_READY;
    assign dat[g]  = bus.oROW_DATA;
    assign wdat[g] = bus.oMEM0WrDATA;
    assign adr[g]  = bus.oMEM0ADDR;

    bnn_mem0_sequencer #(.RD_LAT(g + 1)) dut (
      .iCLK  (clk),
      .iRSTn (rst_n),
      .iCLR  (clr[g]),
      .iSTART(start[g]),
      .bus   (bus),
      .oBUSY (busy[g]),
      .oDONE (done[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int g, input string tag);
    int n = 0;
    while (vld[g] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, vld[g]}, 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy[1]}, 0);
    chk({tag, "_done"}, {31'd0, done[1]}, 0);
    chk({tag, "_valid"}, {31'd0, vld[1]}, 0);
    chk({tag, "_last"}, {31'd0, lst[1]}, 0);
    chk({tag, "_rd_en"}, {31'd0, rden[1]}, 0);
    chk({tag, "_wr_en"}, {31'd0, wren[1]}, 0);
    chk({tag, "_res_ready"}, {31'd0, rrdy[1]}, 0);
    chk({tag, "_addr"}, {26'd0, adr[1]}, 0);
    chk({tag, "_row_data"}, {4'd0, dat[1]}, 0);
    chk({tag, "_wr_data"}, {4'd0, wdat[1]}, 0);
  endtask

  // Full inference on instance 1: optional READY stalls, ignored-input injection, restart-on-DONE.
  task automatic run_rows(input logic [27:0] stall, input bit inject, input logic [3:0] cls, input bit b2b);
    int t0, tp, rd0, wr0;
    rd0 = g_dut[1].rd_cnt;
    wr0 = g_dut[1].wr_cnt;
    start[1] = 1'b1;
    t0 = cyc;
    tp = cyc;
    @(negedge clk);
    start[1] = 1'b0;
    chk("rd_req_en", {31'd0, rden[1]}, 1);
    chk("rd_req_addr", {26'd0, adr[1]}, 0);
    chk("busy_run", {31'd0, busy[1]}, 1);
    for (int r = 0; r < 28; r++) begin
      wait_valid(1, "row_valid");
      if (r == 0) chk("first_latency", cyc - t0, 4);
      else chk("row_gap", cyc - tp, 4);
      chk("row_data", {4'd0, dat[1]}, 32'h100 + r);
      chk("row_last", {31'd0, lst[1]}, (r == 27) ? 1 : 0);
      if (stall[r]) begin
        ready[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("stall_valid", {31'd0, vld[1]}, 1);
          chk("stall_data", {4'd0, dat[1]}, 32'h100 + r);
          chk("stall_last", {31'd0, lst[1]}, (r == 27) ? 1 : 0);
          chk("stall_no_rd", {31'd0, rden[1]}, 0);
        end
        ready[1] = 1'b1;
      end
      if (inject && r == 5) begin
        start[1]     = 1'b1;
        res_valid[1] = 1'b1;
        res_class    = 4'd9;
      end
      tp = cyc;
      @(negedge clk);
      start[1]     = 1'b0;
      res_valid[1] = 1'b0;
      chk("valid_drop", {31'd0, vld[1]}, 0);
    end
    chk("res_ready", {31'd0, rrdy[1]}, 1);
    if (inject) begin
      start[1] = 1'b1;
      @(negedge clk);
      start[1] = 1'b0;
      @(negedge clk);
      chk("wait_res_start_ignored", {31'd0, rrdy[1]}, 1);
      chk("wait_res_no_rd", {31'd0, rden[1]}, 0);
    end
    res_class    = cls;
    res_valid[1] = 1'b1;
    @(negedge clk);
    res_valid[1] = 1'b0;
    chk("wr_en", {31'd0, wren[1]}, 1);
    chk("wr_addr", {26'd0, adr[1]}, 28);
    chk("wr_data", {4'd0, wdat[1]}, {28'd0, cls});
    chk("res_ready_drop", {31'd0, rrdy[1]}, 0);
    @(negedge clk);
    chk("done_pulse", {31'd0, done[1]}, 1);
    chk("wr_en_single", {31'd0, wren[1]}, 0);
    chk("addr_hold", {26'd0, adr[1]}, 28);
    if (b2b) start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    chk("done_end", {31'd0, done[1]}, 0);
    chk("busy_end", {31'd0, busy[1]}, 0);
    chk("b2b_no_rd", {31'd0, rden[1]}, 0);
    chk("read_count", g_dut[1].rd_cnt - rd0, 28);
    chk("write_count", g_dut[1].wr_cnt - wr0, 1);
    chk("rd_wr_clash", g_dut[1].clash, 0);
  endtask

  task automatic sweep(input int g, input int lat);
    int t0, tp;
    start[g] = 1'b1;
    t0 = cyc;
    tp = cyc;
    @(negedge clk);
    start[g] = 1'b0;
    for (int r = 0; r < 4; r++) begin
      wait_valid(g, "sweep_valid");
      if (r == 0) chk("sweep_first_latency", cyc - t0, lat + 2);
      else chk("sweep_gap", cyc - tp, lat + 2);
      chk("sweep_data", {4'd0, dat[g]}, 32'h100 + r);
      tp = cyc;
      @(negedge clk);
    end
  endtask

  initial begin
    int w0, r0;
    rst_n = 1'b0;
    start = '0;
    clr = '0;
    ready = 3'b111;
    res_valid = '0;
    res_class = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", {31'd0, busy[1]}, 0);

    run_rows(28'd0, 1'b0, 4'd7, 1'b1);
    run_rows((28'd1 << 3) | (28'd1 << 27), 1'b0, 4'd5, 1'b0);
    run_rows(28'd0, 1'b1, 4'd2, 1'b0);

    sweep(0, 1);
    sweep(2, 3);

    // Abort in PRESENT of row 10.
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    for (int r = 0; r <= 10; r++) begin
      wait_valid(1, "abort_valid");
      if (r < 10) @(negedge clk);
    end
    chk("abort_row10", {4'd0, dat[1]}, 32'h10A);
    w0 = g_dut[1].wr_cnt;
    clr[1] = 1'b1;
    @(negedge clk);
    clr[1] = 1'b0;
    chk_all_zero("abort");
    repeat (4) @(negedge clk);
    chk("abort_idle", {31'd0, busy[1]}, 0);
    chk("abort_no_write", g_dut[1].wr_cnt - w0, 0);
    run_rows(28'd0, 1'b0, 4'd3, 1'b0);

    // Asynchronous reset during RD_WAIT of row 1.
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    wait_valid(1, "arst_row0");
    @(negedge clk);
    chk("arst_rd_req_addr", {26'd0, adr[1]}, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy[1]}, 0);
    chk("arst_addr", {26'd0, adr[1]}, 0);
    @(negedge clk);
    #3 rst_n = 1'b1;
    r0 = g_dut[1].rd_cnt;
    repeat (6) @(negedge clk);
    chk("arst_idle_busy", {31'd0, busy[1]}, 0);
    chk("arst_idle_valid", {31'd0, vld[1]}, 0);
    chk("arst_idle_no_rd", g_dut[1].rd_cnt - r0, 0);
    run_rows(28'd0, 1'b0, 4'd11, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end
endmodule
